// File: rtl/decode_fwd_pkg.sv
// Shared Y86-64 encodings for the decode stage: instruction codes, status codes
// and the control half of the D->E pipeline register.
package decode_fwd_pkg;

  typedef enum logic [3:0] {
    IHALT   = 4'h0,
    INOP    = 4'h1,
    IRRMOVQ = 4'h2,
    IIRMOVQ = 4'h3,
    IRMMOVQ = 4'h4,
    IMRMOVQ = 4'h5,
    IOPQ    = 4'h6,
    IJXX    = 4'h7,
    ICALL   = 4'h8,
    IRET    = 4'h9,
    IPUSHQ  = 4'hA,
    IPOPQ   = 4'hB
  } icode_e;

  localparam logic [3:0] RRSP  = 4'h4;
  localparam logic [3:0] RNONE = 4'hF;

  localparam logic [2:0] SAOK = 3'd1;
  localparam logic [2:0] SADR = 3'd2;
  localparam logic [2:0] SINS = 3'd3;
  localparam logic [2:0] SHLT = 3'd4;

  typedef struct packed {
    logic [3:0] icode;
    logic [3:0] ifun;
    logic [2:0] stat;
  } e_ctrl_t;

  localparam e_ctrl_t E_CTRL_BUBBLE = '{icode: INOP, ifun: 4'h0, stat: SAOK};

endpackage

// File: rtl/decode_fwd_regfile_2w2r.sv
// Architectural register file: two combinational read ports, two write ports
// (M port wins on a shared id); ids >= NREG, including RNONE, are ignored.
module regfile_2w2r #(
  parameter int DATA_W = 64,
  parameter int NREG   = 15,
  parameter int RID_W  = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [RID_W-1:0]  wr_e_id_i,
  input  logic [DATA_W-1:0] wr_e_dat_i,
  input  logic [RID_W-1:0]  wr_m_id_i,
  input  logic [DATA_W-1:0] wr_m_dat_i,
  input  logic [RID_W-1:0]  rd_a_id_i,
  output logic [DATA_W-1:0] rd_a_dat_o,
  input  logic [RID_W-1:0]  rd_b_id_i,
  output logic [DATA_W-1:0] rd_b_dat_o
);

  localparam logic [RID_W:0]   NREG_W   = NREG[RID_W:0];
  localparam logic [RID_W-1:0] RID_NONE = '1;

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];

  function automatic logic id_ok(input logic [RID_W-1:0] id);
    return ({1'b0, id} < NREG_W) && (id != RID_NONE);
  endfunction

  always_comb begin
    regs_d = regs_q;
    if (id_ok(wr_e_id_i)) regs_d[wr_e_id_i] = wr_e_dat_i;
    // Applied second so the M port wins when both ports target the same id.
    if (id_ok(wr_m_id_i)) regs_d[wr_m_id_i] = wr_m_dat_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // Reads return the pre-write value; same-cycle writes reach decode via forwarding.
  assign rd_a_dat_o = id_ok(rd_a_id_i) ? regs_q[rd_a_id_i] : '0;
  assign rd_b_dat_o = id_ok(rd_b_id_i) ? regs_q[rd_b_id_i] : '0;

endmodule

// File: rtl/decode_fwd.sv
// Y86-64 decode stage: register specifiers, five-way operand forwarding, D->E register.
// Latency 1 cycle D->E; bubble loads a NOP and overrides stall, which holds E.
module decode_fwd
  import decode_fwd_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int NREG   = 15,
  parameter int RID_W  = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              decode_stall_i,
  input  logic              decode_bubble_i,
  input  logic [3:0]        D_icode_i,
  input  logic [3:0]        D_ifun_i,
  input  logic [RID_W-1:0]  D_rA_i,
  input  logic [RID_W-1:0]  D_rB_i,
  input  logic [DATA_W-1:0] D_valC_i,
  input  logic [DATA_W-1:0] D_valP_i,
  input  logic [2:0]        D_stat_i,
  input  logic [RID_W-1:0]  e_dstE_i,
  input  logic [DATA_W-1:0] e_valE_i,
  input  logic [RID_W-1:0]  M_dstM_i,
  input  logic [DATA_W-1:0] m_valM_i,
  input  logic [RID_W-1:0]  M_dstE_i,
  input  logic [DATA_W-1:0] M_valE_i,
  input  logic [RID_W-1:0]  W_dstM_i,
  input  logic [DATA_W-1:0] W_valM_i,
  input  logic [RID_W-1:0]  W_dstE_i,
  input  logic [DATA_W-1:0] W_valE_i,
  output logic [RID_W-1:0]  d_srcA_o,
  output logic [RID_W-1:0]  d_srcB_o,
  output logic [3:0]        E_icode_o,
  output logic [3:0]        E_ifun_o,
  output logic [DATA_W-1:0] E_valC_o,
  output logic [DATA_W-1:0] E_valA_o,
  output logic [DATA_W-1:0] E_valB_o,
  output logic [RID_W-1:0]  E_dstE_o,
  output logic [RID_W-1:0]  E_dstM_o,
  output logic [RID_W-1:0]  E_srcA_o,
  output logic [RID_W-1:0]  E_srcB_o,
  output logic [2:0]        E_stat_o
);

  localparam logic [RID_W-1:0] RID_NONE = '1;
  localparam logic [RID_W-1:0] RID_RSP  = RID_W'(RRSP);

  logic [RID_W-1:0]  src_a, src_b, dst_e, dst_m;
  logic [DATA_W-1:0] rf_a, rf_b, val_a, val_b;

  e_ctrl_t           e_ctrl_q, e_ctrl_d;
  logic [DATA_W-1:0] e_val_c_q, e_val_c_d, e_val_a_q, e_val_a_d, e_val_b_q, e_val_b_d;
  logic [RID_W-1:0]  e_dst_e_q, e_dst_e_d, e_dst_m_q, e_dst_m_d;
  logic [RID_W-1:0]  e_src_a_q, e_src_a_d, e_src_b_q, e_src_b_d;

  always_comb begin
    src_a = RID_NONE;
    src_b = RID_NONE;
    dst_e = RID_NONE;
    dst_m = RID_NONE;
    case (D_icode_i)
      IRRMOVQ: begin src_a = D_rA_i; dst_e = D_rB_i; end
      IIRMOVQ: dst_e = D_rB_i;
      IRMMOVQ: begin src_a = D_rA_i; src_b = D_rB_i; end
      IMRMOVQ: begin src_b = D_rB_i; dst_m = D_rA_i; end
      IOPQ:    begin src_a = D_rA_i; src_b = D_rB_i; dst_e = D_rB_i; end
      ICALL:   begin src_b = RID_RSP; dst_e = RID_RSP; end
      IRET:    begin src_a = RID_RSP; src_b = RID_RSP; dst_e = RID_RSP; end
      IPUSHQ:  begin src_a = D_rA_i; src_b = RID_RSP; dst_e = RID_RSP; end
      IPOPQ:   begin src_a = RID_RSP; src_b = RID_RSP; dst_e = RID_RSP; dst_m = D_rA_i; end
      default: ;
    endcase
  end

  // Youngest producer wins: execute, then memory (load before ALU), then writeback.
  function automatic logic [DATA_W-1:0] fwd(input logic [RID_W-1:0] src,
                                            input logic [DATA_W-1:0] rf);
    if (src == RID_NONE)      return '0;
    else if (src == e_dstE_i) return e_valE_i;
    else if (src == M_dstM_i) return m_valM_i;
    else if (src == M_dstE_i) return M_valE_i;
    else if (src == W_dstM_i) return W_valM_i;
    else if (src == W_dstE_i) return W_valE_i;
    else                      return rf;
  endfunction

  always_comb begin
    val_b = fwd(src_b, rf_b);
    if (D_icode_i == ICALL || D_icode_i == IJXX) val_a = D_valP_i;
    else                                         val_a = fwd(src_a, rf_a);
  end

  regfile_2w2r #(.DATA_W(DATA_W), .NREG(NREG), .RID_W(RID_W)) u_regfile (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .wr_e_id_i  (W_dstE_i),
    .wr_e_dat_i (W_valE_i),
    .wr_m_id_i  (W_dstM_i),
    .wr_m_dat_i (W_valM_i),
    .rd_a_id_i  (src_a),
    .rd_a_dat_o (rf_a),
    .rd_b_id_i  (src_b),
    .rd_b_dat_o (rf_b)
  );

  always_comb begin
    e_ctrl_d  = e_ctrl_q;
    e_val_c_d = e_val_c_q;
    e_val_a_d = e_val_a_q;
    e_val_b_d = e_val_b_q;
    e_dst_e_d = e_dst_e_q;
    e_dst_m_d = e_dst_m_q;
    e_src_a_d = e_src_a_q;
    e_src_b_d = e_src_b_q;
    if (decode_bubble_i) begin
      e_ctrl_d  = E_CTRL_BUBBLE;
      e_val_c_d = '0;
      e_val_a_d = '0;
      e_val_b_d = '0;
      e_dst_e_d = RID_NONE;
      e_dst_m_d = RID_NONE;
      e_src_a_d = RID_NONE;
      e_src_b_d = RID_NONE;
    end else if (!decode_stall_i) begin
      e_ctrl_d  = '{icode: D_icode_i, ifun: D_ifun_i, stat: D_stat_i};
      e_val_c_d = D_valC_i;
      e_val_a_d = val_a;
      e_val_b_d = val_b;
      e_dst_e_d = dst_e;
      e_dst_m_d = dst_m;
      e_src_a_d = src_a;
      e_src_b_d = src_b;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      e_ctrl_q  <= E_CTRL_BUBBLE;
      e_val_c_q <= '0;
      e_val_a_q <= '0;
      e_val_b_q <= '0;
      e_dst_e_q <= RID_NONE;
      e_dst_m_q <= RID_NONE;
      e_src_a_q <= RID_NONE;
      e_src_b_q <= RID_NONE;
    end else begin
      e_ctrl_q  <= e_ctrl_d;
      e_val_c_q <= e_val_c_d;
      e_val_a_q <= e_val_a_d;
      e_val_b_q <= e_val_b_d;
      e_dst_e_q <= e_dst_e_d;
      e_dst_m_q <= e_dst_m_d;
      e_src_a_q <= e_src_a_d;
      e_src_b_q <= e_src_b_d;
    end
  end

  assign d_srcA_o  = src_a;
  assign d_srcB_o  = src_b;
  assign E_icode_o = e_ctrl_q.icode;
  assign E_ifun_o  = e_ctrl_q.ifun;
  assign E_stat_o  = e_ctrl_q.stat;
  assign E_valC_o  = e_val_c_q;
  assign E_valA_o  = e_val_a_q;
  assign E_valB_o  = e_val_b_q;
  assign E_dstE_o  = e_dst_e_q;
  assign E_dstM_o  = e_dst_m_q;
  assign E_srcA_o  = e_src_a_q;
  assign E_srcB_o  = e_src_b_q;

endmodule

// File: tb/tb_decode_fwd.sv
// Scoreboard bench for decode_fwd: directed plan items plus randomized traffic
// checked against a table-driven reference model.
module tb_decode_fwd;
  import decode_fwd_pkg::*;

  localparam int NR = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall, bubble;
  logic [3:0]  D_icode, D_ifun, D_rA, D_rB;
  logic [63:0] D_valC, D_valP;
  logic [2:0]  D_stat;
  logic [3:0]  e_dstE, M_dstM, M_dstE, W_dstM, W_dstE;
  logic [63:0] e_valE, m_valM, M_valE, W_valM, W_valE;
  logic [3:0]  d_srcA, d_srcB, E_icode, E_ifun, E_dstE, E_dstM, E_srcA, E_srcB;
  logic [63:0] E_valC, E_valA, E_valB;
  logic [2:0]  E_stat;

  always #5 clk = ~clk;

  decode_fwd dut (
    .clk_i(clk), .rst_i(rst), .decode_stall_i(stall), .decode_bubble_i(bubble),
    .D_icode_i(D_icode), .D_ifun_i(D_ifun), .D_rA_i(D_rA), .D_rB_i(D_rB),
    .D_valC_i(D_valC), .D_valP_i(D_valP), .D_stat_i(D_stat),
    .e_dstE_i(e_dstE), .e_valE_i(e_valE), .M_dstM_i(M_dstM), .m_valM_i(m_valM),
    .M_dstE_i(M_dstE), .M_valE_i(M_valE), .W_dstM_i(W_dstM), .W_valM_i(W_valM),
    .W_dstE_i(W_dstE), .W_valE_i(W_valE),
    .d_srcA_o(d_srcA), .d_srcB_o(d_srcB), .E_icode_o(E_icode), .E_ifun_o(E_ifun),
    .E_valC_o(E_valC), .E_valA_o(E_valA), .E_valB_o(E_valB),
    .E_dstE_o(E_dstE), .E_dstM_o(E_dstM), .E_srcA_o(E_srcA), .E_srcB_o(E_srcB),
    .E_stat_o(E_stat)
  );

  typedef struct {
    logic [3:0]  srca, srcb;
    logic [3:0]  icode, ifun, dste, dstm, esrca, esrcb;
    logic [63:0] valc, vala, valb;
    logic [2:0]  stat;
  } exp_t;

  exp_t        q[$];
  exp_t        e_m;
  logic [63:0] rf_m [NR];
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, expv);
    end
  endtask

  function automatic logic [3:0] m_srca(input logic [3:0] ic, input logic [3:0] ra);
    if (ic inside {IRRMOVQ, IRMMOVQ, IOPQ, IPUSHQ}) return ra;
    if (ic inside {IPOPQ, IRET}) return RRSP;
    return RNONE;
  endfunction

  function automatic logic [3:0] m_srcb(input logic [3:0] ic, input logic [3:0] rb);
    if (ic inside {IOPQ, IRMMOVQ, IMRMOVQ}) return rb;
    if (ic inside {ICALL, IPUSHQ, IPOPQ, IRET}) return RRSP;
    return RNONE;
  endfunction

  function automatic logic [3:0] m_dste(input logic [3:0] ic, input logic [3:0] rb);
    if (ic inside {IRRMOVQ, IIRMOVQ, IOPQ}) return rb;
    if (ic inside {IPUSHQ, IPOPQ, ICALL, IRET}) return RRSP;
    return RNONE;
  endfunction

  function automatic logic [3:0] m_dstm(input logic [3:0] ic, input logic [3:0] ra);
    return (ic inside {IMRMOVQ, IPOPQ}) ? ra : RNONE;
  endfunction

  function automatic logic [63:0] m_fwd(input logic [3:0] src);
    logic [3:0]  dl [5];
    logic [63:0] vl [5];
    if (src == RNONE) return 64'h0;
    dl = '{e_dstE, M_dstM, M_dstE, W_dstM, W_dstE};
    vl = '{e_valE, m_valM, M_valE, W_valM, W_valE};
    for (int k = 0; k < 5; k++) if (dl[k] == src) return vl[k];
    return (int'(src) < NR) ? rf_m[src] : 64'h0;
  endfunction

  function automatic exp_t bubble_val();
    exp_t b;
    b.srca = RNONE; b.srcb = RNONE;
    b.icode = INOP; b.ifun = 4'h0; b.stat = SAOK;
    b.dste = RNONE; b.dstm = RNONE; b.esrca = RNONE; b.esrcb = RNONE;
    b.valc = 64'h0; b.vala = 64'h0; b.valb = 64'h0;
    return b;
  endfunction

  // Model one clock edge with the currently driven inputs; push what E must show after it.
  task automatic issue();
    exp_t x;
    x.srca = m_srca(D_icode, D_rA);
    x.srcb = m_srcb(D_icode, D_rB);
    if (bubble) e_m = bubble_val();
    else if (!stall) begin
      e_m.icode = D_icode; e_m.ifun = D_ifun; e_m.stat = D_stat;
      e_m.valc  = D_valC;
      e_m.vala  = (D_icode inside {ICALL, IJXX}) ? D_valP : m_fwd(x.srca);
      e_m.valb  = m_fwd(x.srcb);
      e_m.dste  = m_dste(D_icode, D_rB);
      e_m.dstm  = m_dstm(D_icode, D_rA);
      e_m.esrca = x.srca;
      e_m.esrcb = x.srcb;
    end
    x.icode = e_m.icode; x.ifun = e_m.ifun; x.stat = e_m.stat;
    x.valc = e_m.valc; x.vala = e_m.vala; x.valb = e_m.valb;
    x.dste = e_m.dste; x.dstm = e_m.dstm; x.esrca = e_m.esrca; x.esrcb = e_m.esrcb;
    if (int'(W_dstE) < NR) rf_m[W_dstE] = W_valE;
    if (int'(W_dstM) < NR) rf_m[W_dstM] = W_valM;
    q.push_back(x);
  endtask

  task automatic cyc();
    issue();
    @(negedge clk);
  endtask

  task automatic idle();
    stall = 1'b0; bubble = 1'b0;
    D_icode = INOP; D_ifun = 4'h0; D_rA = RNONE; D_rB = RNONE;
    D_valC = 64'h0; D_valP = 64'h0; D_stat = SAOK;
    e_dstE = RNONE; M_dstM = RNONE; M_dstE = RNONE; W_dstM = RNONE; W_dstE = RNONE;
    e_valE = 64'h0; m_valM = 64'h0; M_valE = 64'h0; W_valM = 64'h0; W_valE = 64'h0;
  endtask

  function automatic logic [3:0] rid_rand();
    return ($urandom_range(0, 3) == 0) ? RNONE : 4'($urandom_range(0, 7));
  endfunction

  task automatic rand_inputs();
    stall   = ($urandom_range(0, 7) == 0);
    bubble  = ($urandom_range(0, 7) == 0);
    D_icode = 4'($urandom_range(0, 13));
    D_ifun  = 4'($urandom_range(0, 15));
    D_rA = rid_rand(); D_rB = rid_rand();
    D_valC = {$urandom, $urandom}; D_valP = {$urandom, $urandom};
    D_stat = 3'($urandom_range(1, 4));
    e_dstE = rid_rand(); M_dstM = rid_rand(); M_dstE = rid_rand();
    W_dstM = rid_rand(); W_dstE = rid_rand();
    e_valE = {$urandom, $urandom}; m_valM = {$urandom, $urandom};
    M_valE = {$urandom, $urandom}; W_valM = {$urandom, $urandom};
    W_valE = {$urandom, $urandom};
  endtask

  // Asserted just after a falling edge so the following rising edge carries a write that must be lost.
  task automatic do_reset();
    W_dstE = 4'($urandom_range(0, 14)); W_valE = {$urandom, $urandom};
    rst = 1'b1;
    #1;
    chk("rst_icode", E_icode, INOP);
    chk("rst_ifun",  E_ifun,  4'h0);
    chk("rst_dstE",  E_dstE,  RNONE);
    chk("rst_dstM",  E_dstM,  RNONE);
    chk("rst_srcA",  E_srcA,  RNONE);
    chk("rst_srcB",  E_srcB,  RNONE);
    chk("rst_valA",  E_valA,  64'h0);
    chk("rst_valB",  E_valB,  64'h0);
    chk("rst_valC",  E_valC,  64'h0);
    chk("rst_stat",  E_stat,  SAOK);
    for (int i = 0; i < NR; i++) rf_m[i] = 64'h0;
    e_m = bubble_val();
    @(negedge clk);
    rst = 1'b0;
    idle();
  endtask

  // Monitor: combinational sources before the edge, E register after it.
  initial begin
    exp_t cur;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        cur = q[0];
        chk("d_srcA", d_srcA, cur.srca);
        chk("d_srcB", d_srcB, cur.srcb);
        @(posedge clk);
        #1;
        cur = q.pop_front();
        chk("E_icode", E_icode, cur.icode);
        chk("E_ifun",  E_ifun,  cur.ifun);
        chk("E_stat",  E_stat,  cur.stat);
        chk("E_valC",  E_valC,  cur.valc);
        chk("E_valA",  E_valA,  cur.vala);
        chk("E_valB",  E_valB,  cur.valb);
        chk("E_dstE",  E_dstE,  cur.dste);
        chk("E_dstM",  E_dstM,  cur.dstm);
        chk("E_srcA",  E_srcA,  cur.esrca);
        chk("E_srcB",  E_srcB,  cur.esrcb);
      end
    end
  end

  initial begin
    idle();
    #3;
    do_reset();

    W_dstE = 4'd3; W_valE = 64'h55;
    cyc();
    idle(); D_icode = IOPQ; D_rA = 4'd3; D_rB = 4'd3;
    cyc();
    chk("rf_opq_valA", E_valA, 64'h55);
    chk("rf_opq_valB", E_valB, 64'h55);
    chk("rf_opq_dstE", E_dstE, 64'd3);

    idle(); D_icode = IOPQ; D_rA = 4'd2; D_rB = 4'd6;
    e_dstE = 4'd2; e_valE = 64'h11; M_dstM = 4'd2; m_valM = 64'h22;
    W_dstE = 4'd2; W_valE = 64'h33;
    cyc();
    chk("fwd_prio_e", E_valA, 64'h11);
    e_dstE = RNONE;
    cyc();
    chk("fwd_prio_m", E_valA, 64'h22);

    idle(); W_dstE = 4'd4; W_valE = 64'h200;
    cyc();
    idle(); D_icode = ICALL; D_valP = 64'h1000;
    cyc();
    chk("call_valA", E_valA, 64'h1000);
    chk("call_valB", E_valB, 64'h200);
    chk("call_srcB", E_srcB, 64'd4);
    chk("call_dstE", E_dstE, 64'd4);

    idle(); W_dstE = 4'd5; W_valE = 64'hAA; W_dstM = 4'd5; W_valM = 64'hBB;
    cyc();
    idle(); D_icode = IOPQ; D_rA = 4'd5; D_rB = 4'd5;
    cyc();
    chk("wr_same_id_valA", E_valA, 64'hBB);

    for (int i = 0; i < 2; i++) begin
      rand_inputs(); stall = 1'b1; bubble = 1'b0;
      cyc();
      chk("stall_icode", E_icode, IOPQ);
      chk("stall_valA",  E_valA,  64'hBB);
    end
    rand_inputs(); stall = 1'b1; bubble = 1'b1;
    cyc();
    chk("stall_bubble_icode", E_icode, INOP);
    chk("stall_bubble_dstE",  E_dstE,  RNONE);

    do_reset();
    D_icode = IOPQ; D_rA = 4'd5; D_rB = 4'd3;
    cyc();
    chk("post_rst_rf_a", E_valA, 64'h0);
    chk("post_rst_rf_b", E_valB, 64'h0);

    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      rand_inputs();
      cyc();
    end

    idle();
    for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
    chk("scoreboard_drained", 64'(q.size()), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
